cmd_proc: RTL

- Command processor that sits directly downstream of the 2-byte UART command wrapper.
- Consumes each 16-bit command presented on cmd/cmd_rdy and acknowledges it with a clr_cmd_rdy pulse.
- Executes the command against a small configuration register file, then returns one response byte through send_resp/resp and waits for resp_sent.
- Its register contents drive configuration for the rest of the design.

---
 rtl/cmd_pkg.sv | 48 ++++
 rtl/cmd_if.sv | 29 ++
 rtl/cmd_regfile.sv | 56 +++++
 rtl/cmd_proc.sv | 119 +++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// ---------------------------------------------------------------------------
// cmd_pkg
// Shared types and constants for the command processor:
//   opcode_e  - command opcodes carried in cmd[15:12]
//   state_e   - command processor FSM states
//   cmd_t     - field view of the 16-bit command word
//   RESP_ACK / RESP_NAK - fixed response bytes
//   resp_byte - response byte for a decoded command
// ---------------------------------------------------------------------------
package cmd_pkg;

    typedef enum logic [3:0] {
        OP_WRITE = 4'h1,
        OP_READ  = 4'h2,
        OP_ECHO  = 4'h3,
        OP_CLEAR = 4'h4
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SEND,
        WAIT_TX
    } state_e;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] addr;
        logic [7:0] data;
    } cmd_t;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_NAK = 8'hEE;

    // Response for one command. addr_ok says whether addr names an existing
    // register; rdata is the current content of that register.
    function automatic logic [7:0] resp_byte(input cmd_t c, input logic addr_ok,
                                             input logic [7:0] rdata);
        case (c.op)
            OP_WRITE: return addr_ok ? RESP_ACK : RESP_NAK;
            OP_READ:  return addr_ok ? rdata : RESP_NAK;
            OP_ECHO:  return c.data;
            OP_CLEAR: return RESP_ACK;
            default:  return RESP_NAK;
        endcase
    endfunction

endpackage

// File: rtl/cmd_if.sv
// ---------------------------------------------------------------------------
// cmd_if
// Command/response handshake between the UART command wrapper and cmd_proc.
//   cmd         - 16-bit command word, valid while cmd_rdy is high
//   cmd_rdy     - command pending (level, held until clr_cmd_rdy)
//   clr_cmd_rdy - one-cycle acknowledge of the pending command
//   resp        - response byte
//   send_resp   - one-cycle transmit strobe for resp
//   resp_sent   - transmitter done indication
// master: the upstream/transmitter side; slave: cmd_proc.
// ---------------------------------------------------------------------------
interface cmd_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    modport master (
        output cmd, cmd_rdy, resp_sent,
        input  clr_cmd_rdy, resp, send_resp
    );

    modport slave (
        input  cmd, cmd_rdy, resp_sent,
        output clr_cmd_rdy, resp, send_resp
    );
endinterface

// File: rtl/cmd_regfile.sv
// ---------------------------------------------------------------------------
// cmd_regfile
// Bank of NUM_REGS 8-bit configuration registers.
//   clk, rst - clock, synchronous active-high reset (clears every register)
//   we, waddr, wdata - single-register write
//   clr      - clear every register (takes priority over we)
//   raddr, rdata - combinational read; out-of-range addresses read 0
//   cfg_q    - all registers flattened, reg i at [8i+7:8i]
// ---------------------------------------------------------------------------
module cmd_regfile #(
    parameter int NUM_REGS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [3:0]            waddr,
    input  logic [7:0]            wdata,
    input  logic                  clr,
    input  logic [3:0]            raddr,
    output logic [7:0]            rdata,
    output logic [8*NUM_REGS-1:0] cfg_q
);

    logic [7:0] regs [NUM_REGS];

    // NOTE: this array is deliberately reset entry by entry -- it drives live
    // configuration, so it must never power up random; a RAM-style array that
    // only holds data would be left without reset.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: clocked state always uses non-blocking assignment so
                // every register samples its inputs from before the edge.
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (int'(waddr) == i) regs[i] <= wdata;
            end
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the block leaves rdata
        // unassigned and a latch cannot be inferred.
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(raddr) == i) rdata = regs[i];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_q[8*g +: 8] = regs[g];
    end

endmodule

// File: rtl/cmd_proc.sv
// ---------------------------------------------------------------------------
// cmd_proc
// Accepts 16-bit commands from the UART command wrapper, executes them on a
// small configuration register file and returns one response byte per
// command, waiting up to TX_TIMEOUT cycles for the transmitter.
//   clk, rst - clock, synchronous active-high reset
//   bus      - cmd_if.slave: cmd/cmd_rdy/clr_cmd_rdy, resp/send_resp/resp_sent
//   cfg_q    - flattened configuration registers, reg i at [8i+7:8i]
//   busy     - high whenever a command is in progress
//   tx_err   - sticky response-timeout flag, cleared only by rst
//   cmd_cnt  - number of commands whose response was sent (wraps)
// ---------------------------------------------------------------------------
module cmd_proc
    import cmd_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int TX_TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    cmd_if.slave                  bus,
    output logic [8*NUM_REGS-1:0] cfg_q,
    output logic                  busy,
    output logic                  tx_err,
    output logic [7:0]            cmd_cnt
);

    localparam int TIMER_W = (TX_TIMEOUT < 2) ? 1 : $clog2(TX_TIMEOUT + 1);

    state_e               state, state_next;
    cmd_t                 cmd_q;
    logic [7:0]           resp_q;
    logic [TIMER_W-1:0]   timer;
    logic                 addr_ok;
    logic                 rf_we, rf_clr;
    logic [7:0]           rf_rdata;
    logic                 clr_cmd_rdy_c, send_resp_c;

    // The command word is only valid while cmd_rdy is high, so everything
    // after IDLE works from the latched copy.
    assign addr_ok = int'(cmd_q.addr) < NUM_REGS;

    cmd_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (rf_we),
        .waddr (cmd_q.addr),
        .wdata (cmd_q.data),
        .clr   (rf_clr),
        .raddr (cmd_q.addr),
        .rdata (rf_rdata),
        .cfg_q (cfg_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        clr_cmd_rdy_c = 1'b0;
        send_resp_c   = 1'b0;
        busy          = 1'b1;
        rf_we         = 1'b0;
        rf_clr        = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.cmd_rdy) state_next = EXEC;
            end
            EXEC: begin
                clr_cmd_rdy_c = 1'b1;
                rf_we         = (cmd_q.op == OP_WRITE) && addr_ok;
                rf_clr        = (cmd_q.op == OP_CLEAR);
                state_next    = SEND;
            end
            SEND: begin
                send_resp_c = 1'b1;
                state_next  = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.resp_sent || timer == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q   <= '0;
            resp_q  <= '0;
            timer   <= '0;
            cmd_cnt <= '0;
            tx_err  <= 1'b0;
        end else begin
            unique case (state)
                IDLE:    if (bus.cmd_rdy) cmd_q <= bus.cmd;
                // READ samples the register before any write of this cycle;
                // WRITE and READ are different opcodes so they never overlap.
                EXEC:    resp_q <= resp_byte(cmd_q, addr_ok, rf_rdata);
                SEND:    timer <= TIMER_W'(TX_TIMEOUT);
                WAIT_TX: begin
                    // A completion arriving on the last timer cycle still
                    // counts as success.
                    if (bus.resp_sent)    cmd_cnt <= cmd_cnt + 8'd1;
                    else if (timer == '0) tx_err  <= 1'b1;
                    else                  timer   <= timer - TIMER_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.clr_cmd_rdy = clr_cmd_rdy_c;
    assign bus.send_resp   = send_resp_c;
    assign bus.resp        = resp_q;

endmodule
